hazard_stall_2w: RTL
====================

# hazard_stall_2w

Stall and interlock unit for the 2-wide pipeline. It covers the hazards the forwarding network cannot resolve: load-use, intra-packet RAW between pipe 1 and pipe 2, and dependencies on an in-flight multi-cycle mult/div. It sits at the F/D–D/X boundary. It holds PC and the FD latches and injects nops into the DX latch per pipe.

## Interface
Parameters:
- MD_TIMEOUT, 63, watchdog limit in cycles (used only with the configuration macro).

Ports:
- clock  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- FD_rs_1, FD_rt_1, FD_rd_1  in  5 each  pipe-1 decode register fields.
- FD_rs_2, FD_rt_2, FD_rd_2  in  5 each  pipe-2 decode register fields.
- FD_regWrite_1  in  1  pipe-1 decode instruction writes FD_rd_1.
- FD_isMD_1  in  1  pipe-1 decode instruction is mult/div. Steering guarantees mult/div never appears in pipe 2.
- DX_memRead_1, DX_memRead_2  in  1 each  DX-stage instruction is a load.
- DX_rd_1, DX_rd_2  in  5 each  DX-stage destinations.
- md_rdy  in  1  single-cycle pulse from the mult/div unit: result valid.
- stall_FD  out  1  hold PC and both FD latches.
- bubble_DX_1, bubble_DX_2  out  1 each  load a nop into that pipe's DX latch.
- md_busy  out  1  mult/div result pending.
- md_rd  out  5  destination of the pending mult/div.
- md_err  out  1  sticky watchdog error (configuration macro only; otherwise tied 0).

## Operation
- Two independent registered FSMs:
  - Issue FSM: RUN / SPLIT.
  - MD tracker: IDLE / BUSY. Its state drives md_busy.
- Active sources:
  - In RUN, both pipes' rs and rt are active.
  - In SPLIT, only pipe 2's rs and rt are active.
  - rt is always treated as used (conservative).
- Hazard conditions, evaluated combinationally each cycle:
  - LU (load-use): any k with DX_memRead_k, DX_rd_k≠0, and DX_rd_k equal to an active source.
  - MDH (mult/div dependency): md_busy, md_rd≠0, and md_rd equal to an active source or an active-pipe rd (WAW). Also asserted when md_busy and FD_isMD_1 in RUN.
  - IP (intra-packet RAW): RUN, FD_regWrite_1, FD_rd_1≠0, and FD_rd_1 ∈ {FD_rs_2, FD_rt_2}.
- Priority: reset > LU > MDH > IP.
- Actions:
  - LU or MDH: stall_FD=1, bubble_DX_1=1, bubble_DX_2=1. Issue state is unchanged.
  - IP (no LU/MDH): stall_FD=1, bubble_DX_2=1. Pipe 1 issues. Next state is SPLIT.
  - SPLIT with no LU/MDH: bubble_DX_1=1 (pipe 1 already issued), stall_FD=0. Pipe 2 issues. Next state is RUN.
  - MD issue: in RUN, FD_isMD_1 with no LU/MDH. Pipe 1 issues, md_busy is set, and md_rd←FD_rd_1. This can coincide with IP, in which case the state also moves to SPLIT.
  - MD retire: md_rdy while BUSY → IDLE at the next edge. MDH remains asserted during the md_rdy cycle.
  - md_rdy while IDLE: ignored.
- No hazard: all outputs 0 and both pipes issue.

## Timing
- All outputs are combinational from current inputs and registered state. Zero-latency decisions.
- Reset cycle: stall_FD, bubble_DX_1, bubble_DX_2 forced 0. At the next edge: Issue=RUN, MD=IDLE, md_busy=0, md_rd=0, md_err=0, watchdog=0.
- Load-use costs exactly 1 stall cycle, because the load leaves DX.
- IP costs exactly 1 cycle (SPLIT).
- MDH stall spans every cycle up to and including the md_rdy cycle. The dependent instruction issues the cycle after md_rdy.
- md_rdy in the same cycle as a new FD_isMD_1 while BUSY: the new mult/div stalls that cycle and issues next cycle. md_rd then updates.
- Reset mid-SPLIT or mid-BUSY: state is discarded; the pending mult/div is abandoned.

## Configuration
- HAZ_MD_WATCHDOG_EN defined:
  - A 6-bit counter clears on MD issue and increments each BUSY cycle without md_rdy.
  - When it reaches MD_TIMEOUT, the MD tracker is forced to IDLE and md_err sets (sticky until reset).
- HAZ_MD_WATCHDOG_EN undefined:
  - No counter is present and md_err is tied 0.
  - BUSY persists until md_rdy.

## Test plan
- Load-use: DX_memRead_1=1, DX_rd_1=5, FD_rt_2=5 → one cycle of stall_FD=1 with both bubbles; then the next cycle (DX_memRead_1=0) all outputs are 0.
- IP: FD_regWrite_1=1, FD_rd_1=3, FD_rs_2=3 → cycle 0: stall_FD=1, bubble_DX_2=1. Cycle 1 (SPLIT): bubble_DX_1=1, stall_FD=0. Cycle 2: RUN.
- MD: FD_isMD_1=1, FD_rd_1=7 issues → md_busy=1, md_rd=7. The next packet has FD_rs_1=7 and stalls. md_rdy arrives 4 cycles later; the packet issues on the following cycle and md_busy=0.
- Independent instructions during BUSY: md_rd=7, packet uses r1/r2 → no stall. A packet with FD_rd_2=7 (WAW) → stall.
- Register 0 immunity: DX_memRead_1=1, DX_rd_1=0, FD_rs_1=0 → no stall. Reset asserted mid-SPLIT → next cycle RUN, all outputs 0.
- HAZ_MD_WATCHDOG_EN with MD_TIMEOUT=63: issue mult/div and never pulse md_rdy → at the 63rd BUSY cycle md_busy→0 and md_err→1, held until reset.

Source files
------------

// File: rtl/hazard_stall_2w.sv
// hazard_stall_2w: stall/interlock unit for the 2-wide pipeline at the FD/DX boundary.
// Resolves load-use, intra-packet RAW (pipe 1 -> pipe 2) and in-flight mult/div
// dependencies by holding PC/FD and injecting per-pipe nops into DX.
// Optional feature macro: HAZ_MD_WATCHDOG_EN (mult/div watchdog with sticky md_err).
module hazard_stall_2w #(
  parameter int unsigned MD_TIMEOUT = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] FD_rs_1,
  input  logic [4:0] FD_rt_1,
  input  logic [4:0] FD_rd_1,
  input  logic [4:0] FD_rs_2,
  input  logic [4:0] FD_rt_2,
  input  logic [4:0] FD_rd_2,
  input  logic       FD_regWrite_1,
  input  logic       FD_isMD_1,
  input  logic       DX_memRead_1,
  input  logic       DX_memRead_2,
  input  logic [4:0] DX_rd_1,
  input  logic [4:0] DX_rd_2,
  input  logic       md_rdy,
  output logic       stall_FD,
  output logic       bubble_DX_1,
  output logic       bubble_DX_2,
  output logic       md_busy,
  output logic [4:0] md_rd,
  output logic       md_err
);

  localparam int unsigned RW = 5;

  // The watchdog counter is 6 bits wide, so the limit must fit in 1..63.
  if (MD_TIMEOUT == 0 || MD_TIMEOUT > 63) begin : g_bad_timeout
    $error("hazard_stall_2w: MD_TIMEOUT must be in 1..63");
  end

  typedef enum logic {
    ISS_RUN   = 1'b0,
    ISS_SPLIT = 1'b1
  } iss_state_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  iss_state_e    iss_q, iss_d;
  md_state_e     md_q, md_d;
  logic [RW-1:0] md_rd_q, md_rd_d;

`ifdef HAZ_MD_WATCHDOG_EN
  localparam logic [5:0] WD_LIMIT = 6'(MD_TIMEOUT);
  logic [5:0] wd_cnt_q, wd_cnt_d;
  logic       md_err_q, md_err_d;
`endif

  logic in_run;
  logic haz_lu;
  logic haz_mdh;
  logic haz_ip;
  logic md_issue;

  // True when register r matches a source that is live in the current issue state.
  function automatic logic src_hit(
    input logic [RW-1:0] r,
    input logic          run,
    input logic [RW-1:0] rs1,
    input logic [RW-1:0] rt1,
    input logic [RW-1:0] rs2,
    input logic [RW-1:0] rt2
  );
    src_hit = (run && ((r == rs1) || (r == rt1))) || (r == rs2) || (r == rt2);
  endfunction

  // Hazard detection from current decode/DX fields and tracked state.
  always_comb begin
    in_run = (iss_q == ISS_RUN);

    haz_lu = (DX_memRead_1 && (DX_rd_1 != '0) &&
              src_hit(DX_rd_1, in_run, FD_rs_1, FD_rt_1, FD_rs_2, FD_rt_2)) ||
             (DX_memRead_2 && (DX_rd_2 != '0) &&
              src_hit(DX_rd_2, in_run, FD_rs_1, FD_rt_1, FD_rs_2, FD_rt_2));

    haz_mdh = (md_q == MD_BUSY) &&
              (((md_rd_q != '0) &&
                (src_hit(md_rd_q, in_run, FD_rs_1, FD_rt_1, FD_rs_2, FD_rt_2) ||
                 (in_run && (md_rd_q == FD_rd_1)) ||
                 (md_rd_q == FD_rd_2))) ||
               (in_run && FD_isMD_1));

    haz_ip = in_run && FD_regWrite_1 && (FD_rd_1 != '0) &&
             ((FD_rd_1 == FD_rs_2) || (FD_rd_1 == FD_rt_2));

    md_issue = in_run && FD_isMD_1 && !haz_lu && !haz_mdh;
  end

  // Stall/bubble outputs and next-state for both trackers.
  always_comb begin
    stall_FD    = 1'b0;
    bubble_DX_1 = 1'b0;
    bubble_DX_2 = 1'b0;
    iss_d       = iss_q;
    md_d        = md_q;
    md_rd_d     = md_rd_q;
`ifdef HAZ_MD_WATCHDOG_EN
    wd_cnt_d    = wd_cnt_q;
    md_err_d    = md_err_q;
`endif

    // Issue decisions; load-use and mult/div dependency freeze the issue state.
    if (!reset) begin
      if (haz_lu || haz_mdh) begin
        stall_FD    = 1'b1;
        bubble_DX_1 = 1'b1;
        bubble_DX_2 = 1'b1;
      end else if (iss_q == ISS_SPLIT) begin
        bubble_DX_1 = 1'b1;
        iss_d       = ISS_RUN;
      end else if (haz_ip) begin
        stall_FD    = 1'b1;
        bubble_DX_2 = 1'b1;
        iss_d       = ISS_SPLIT;
      end
    end

    // Mult/div tracker: retire on md_rdy, optional watchdog, then new issue.
    if (md_q == MD_BUSY) begin
      if (md_rdy) begin
        md_d = MD_IDLE;
      end else begin
`ifdef HAZ_MD_WATCHDOG_EN
        wd_cnt_d = wd_cnt_q + 6'd1;
        if (wd_cnt_d == WD_LIMIT) begin
          md_d     = MD_IDLE;
          md_err_d = 1'b1;
        end
`endif
      end
    end

    if (md_issue) begin
      md_d    = MD_BUSY;
      md_rd_d = FD_rd_1;
`ifdef HAZ_MD_WATCHDOG_EN
      wd_cnt_d = '0;
`endif
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      iss_q    <= ISS_RUN;
      md_q     <= MD_IDLE;
      md_rd_q  <= '0;
`ifdef HAZ_MD_WATCHDOG_EN
      wd_cnt_q <= '0;
      md_err_q <= 1'b0;
`endif
    end else begin
      iss_q    <= iss_d;
      md_q     <= md_d;
      md_rd_q  <= md_rd_d;
`ifdef HAZ_MD_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
      md_err_q <= md_err_d;
`endif
    end
  end

  assign md_busy = (md_q == MD_BUSY);
  assign md_rd   = md_rd_q;

`ifdef HAZ_MD_WATCHDOG_EN
  assign md_err = md_err_q;
`else
  assign md_err = 1'b0;
`endif

endmodule
